// File: rtl/cbus_master_bridge_pkg.sv
// Shared CBus constants: address map, FSM encoding and error payload.
// Consumers: cbus_master_bridge, cbus_addr_decode (and the read-merge side).
package cbus_master_bridge_pkg;

  localparam int unsigned CBUS_ADDR_W = 18;
  localparam int unsigned CBUS_DATA_W = 32;

  // Slave windows: the upper address bits select the slave.
  localparam logic [CBUS_ADDR_W-1:0] CBUS_BASE_MASK   = 18'h3ff00;
  localparam logic [CBUS_ADDR_W-1:0] CBUS_AXI2S_BASE  = 18'h00100;
  localparam logic [CBUS_ADDR_W-1:0] CBUS_AD9361_BASE = 18'h00200;

  // Read data returned for an access that hits no slave window.
  localparam logic [CBUS_DATA_W-1:0] CBUS_DECERR_DATA = 32'hDEADBEEF;

  // Bridge FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Latency counter width; covers RD_LAT-1 for RD_LAT up to 7.
  localparam int unsigned CBUS_LAT_CNT_W = 3;

endpackage

// File: rtl/cbus_addr_decode.sv
// Combinational CBus base decoder: flags whether an address falls into a
// known slave window. Shared between the master bridge and the read merge.
module cbus_addr_decode
  import cbus_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = CBUS_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_c
);

  logic [ADDR_W-1:0] base_c;

  // Mask off the register offset and compare against each slave base.
  always_comb begin
    base_c = addr & ADDR_W'(CBUS_BASE_MASK);
    hit_c  = (base_c == ADDR_W'(CBUS_AXI2S_BASE)) ||
             (base_c == ADDR_W'(CBUS_AD9361_BASE));
  end

endmodule

// File: rtl/cbus_master_bridge.sv
// CBus initiator: turns a valid/ready request stream into single CBus
// read/write cycles and returns read data on a valid/ready response channel.
// One transaction outstanding at a time; all outputs registered.
// Optional build macro CBUS_DECERR_EN: unmapped addresses are not issued on
// the bus and complete with resp_err=1 and CBUS_DECERR_DATA.
module cbus_master_bridge
  import cbus_master_bridge_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              cbus_en,
  output logic              cbus_wen,
  output logic [ADDR_W-1:0] cbus_addr,
  output logic [DATA_W-1:0] cbus_din,
  input  logic [DATA_W-1:0] cbus_rdata
);

  localparam int unsigned CNT_W = CBUS_LAT_CNT_W;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              wr_q, wr_nxt;
  logic              req_ready_nxt;
  logic              resp_valid_nxt;
  logic [DATA_W-1:0] resp_rdata_nxt;
  logic              resp_err_nxt;
  logic              cbus_en_nxt;
  logic              cbus_wen_nxt;
  logic [ADDR_W-1:0] cbus_addr_nxt;
  logic [DATA_W-1:0] cbus_din_nxt;
  logic              issue_go_c;
  logic              addr_hit_c;

  // Decode the incoming address so a miss can suppress the bus cycle that
  // would otherwise launch on the acceptance edge.
  cbus_addr_decode #(
    .ADDR_W (ADDR_W)
  ) u_addr_decode (
    .addr  (req_addr),
    .hit_c (addr_hit_c)
  );

`ifdef CBUS_DECERR_EN
  logic hit_q, hit_nxt;
`else
  logic unused_addr_hit;
  assign unused_addr_hit = addr_hit_c;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    wr_nxt         = wr_q;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    cbus_addr_nxt  = cbus_addr;
    cbus_din_nxt   = cbus_din;
`ifdef CBUS_DECERR_EN
    hit_nxt        = hit_q;
`endif

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt     = ST_ISSUE;
          wr_nxt        = req_write;
          cbus_addr_nxt = req_addr;
          cbus_din_nxt  = req_wdata;
`ifdef CBUS_DECERR_EN
          hit_nxt       = addr_hit_c;
`endif
        end
      end

      ST_ISSUE: begin
`ifdef CBUS_DECERR_EN
        if (!hit_q) begin
          state_nxt      = ST_RESP;
          resp_err_nxt   = 1'b1;
          resp_rdata_nxt = DATA_W'(CBUS_DECERR_DATA);
        end else
`endif
        if (wr_q) begin
          state_nxt      = ST_RESP;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = '0;
        end else begin
          state_nxt   = ST_WAIT;
          lat_cnt_nxt = CNT_W'(RD_LAT - 1);
        end
      end

      ST_WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt      = ST_RESP;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = cbus_rdata;
        end else begin
          lat_cnt_nxt = lat_cnt - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Output registers follow the state being entered.
    issue_go_c = (state_nxt == ST_ISSUE);
`ifdef CBUS_DECERR_EN
    issue_go_c = issue_go_c && hit_nxt;
`endif
    req_ready_nxt  = (state_nxt == ST_IDLE);
    resp_valid_nxt = (state_nxt == ST_RESP);
    cbus_en_nxt    = issue_go_c;
    cbus_wen_nxt   = issue_go_c && wr_nxt;
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      wr_q       <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cbus_en    <= 1'b0;
      cbus_wen   <= 1'b0;
      cbus_addr  <= '0;
      cbus_din   <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      wr_q       <= wr_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      cbus_en    <= cbus_en_nxt;
      cbus_wen   <= cbus_wen_nxt;
      cbus_addr  <= cbus_addr_nxt;
      cbus_din   <= cbus_din_nxt;
    end
  end

`ifdef CBUS_DECERR_EN
  // Decode result of the request currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cbus_master_bridge.sv
// Directed bench for cbus_master_bridge: three instances (RD_LAT 2, 1, 7),
// each with a CBus slave model returning data exactly RD_LAT cycles after en.
module tb_cbus_master_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [17:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        cbus_en    [3];
  logic        cbus_wen   [3];
  logic [17:0] cbus_addr  [3];
  logic [31:0] cbus_din   [3];
  logic [31:0] cbus_rdata [3];

  logic [7:0]  pv [3];
  logic [17:0] pa [3][8];
  int          en_cnt [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cbus_master_bridge #(.RD_LAT(2), .ADDR_W(18), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .cbus_en(cbus_en[0]), .cbus_wen(cbus_wen[0]), .cbus_addr(cbus_addr[0]),
    .cbus_din(cbus_din[0]), .cbus_rdata(cbus_rdata[0]));

  cbus_master_bridge #(.RD_LAT(1), .ADDR_W(18), .DATA_W(32)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .cbus_en(cbus_en[1]), .cbus_wen(cbus_wen[1]), .cbus_addr(cbus_addr[1]),
    .cbus_din(cbus_din[1]), .cbus_rdata(cbus_rdata[1]));

  cbus_master_bridge #(.RD_LAT(7), .ADDR_W(18), .DATA_W(32)) dut_l7 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
    .cbus_en(cbus_en[2]), .cbus_wen(cbus_wen[2]), .cbus_addr(cbus_addr[2]),
    .cbus_din(cbus_din[2]), .cbus_rdata(cbus_rdata[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 7;
  endfunction

  // Slave contents: fixed word at 0x00208, address-tagged data elsewhere in
  // the mapped windows, 0 for unmapped addresses.
  function automatic logic [31:0] model_rd(input logic [17:0] a);
    logic [17:0] b;
    b = a & 18'h3ff00;
    if (a == 18'h00208) return 32'h1234_5678;
    if (b == 18'h00100 || b == 18'h00200) return {8'hC0, 6'h00, a};
    return 32'h0;
  endfunction

  // Read pipeline of each slave: remembers read strobes and their addresses.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pv[i] <= {pv[i][6:0], cbus_en[i] & ~cbus_wen[i]};
      pa[i][0] <= cbus_addr[i];
      for (int k = 1; k < 8; k++) pa[i][k] <= pa[i][k-1];
      en_cnt[i] <= en_cnt[i] + (cbus_en[i] ? 1 : 0);
    end
  end

  // Valid data only in the cycle RD_LAT after en; a decoy one cycle either side.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cbus_rdata[i] = 32'h0;
      if (pv[i][lat_of(i)]) cbus_rdata[i] = 32'hBAD0_BAD0;
      if (lat_of(i) >= 2) begin
        if (pv[i][lat_of(i)-2]) cbus_rdata[i] = 32'hBAD0_BAD0;
      end
      if (pv[i][lat_of(i)-1]) cbus_rdata[i] = model_rd(pa[i][lat_of(i)-1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on instance i and return just after its acceptance edge.
  task automatic send(input int i, input logic w, input logic [17:0] a,
                      input logic [31:0] d, output bit ok);
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = req_ready[i];
      tick();
    end
    req_valid[i] = 1'b0;
  endtask

  // Count edges until resp_valid rises (bounded at 64).
  task automatic wait_resp(input int i, output int cyc);
    cyc = 0;
    while (!resp_valid[i] && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({req_ready[0], resp_valid[0], resp_err[0], cbus_en[0], cbus_wen[0]} !== 5'b0)
      $display("FAIL reset_ctl got=%b exp=00000",
               {req_ready[0], resp_valid[0], resp_err[0], cbus_en[0], cbus_wen[0]});
    else pass_cnt++;
    total_cnt++;
    if ({resp_rdata[0], cbus_addr[0], cbus_din[0]} !== 82'h0)
      $display("FAIL reset_data got=%h exp=0", {resp_rdata[0], cbus_addr[0], cbus_din[0]});
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (req_ready[0] !== 1'b1) $display("FAIL idle_ready got=%b exp=1", req_ready[0]);
    else pass_cnt++;
  endtask

  task automatic test_write();
    bit ok;
    int e0;
    e0 = en_cnt[0];
    send(0, 1'b1, 18'h00104, 32'hA5A5_0001, ok);
    total_cnt++;
    if (!ok || cbus_en[0] !== 1'b1 || cbus_wen[0] !== 1'b1 || req_ready[0] !== 1'b0)
      $display("FAIL wr_issue got=ok%0d en%b wen%b rdy%b exp=ok1 en1 wen1 rdy0",
               ok, cbus_en[0], cbus_wen[0], req_ready[0]);
    else pass_cnt++;
    total_cnt++;
    if (cbus_addr[0] !== 18'h00104 || cbus_din[0] !== 32'hA5A5_0001)
      $display("FAIL wr_bus got=%h/%h exp=00104/a5a50001", cbus_addr[0], cbus_din[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cbus_en[0] !== 1'b0 || resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0)
      $display("FAIL wr_resp got=en%b v%b d%h e%b exp=en0 v1 d0 e0",
               cbus_en[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || en_cnt[0] - e0 !== 1)
      $display("FAIL wr_done got=v%b rdy%b en_pulses%0d exp=v0 rdy1 en_pulses1",
               resp_valid[0], req_ready[0], en_cnt[0] - e0);
    else pass_cnt++;
  endtask

  task automatic test_read();
    bit ok;
    int cyc;
    int wen_seen;
    send(0, 1'b0, 18'h00208, 32'hFFFF_FFFF, ok);
    wen_seen = (cbus_wen[0] === 1'b1) ? 1 : 0;
    total_cnt++;
    if (!ok || cbus_en[0] !== 1'b1) $display("FAIL rd_issue got=ok%0d en%b exp=ok1 en1", ok, cbus_en[0]);
    else pass_cnt++;
    cyc = 0;
    while (!resp_valid[0] && cyc < 64) begin
      tick();
      cyc++;
      if (cbus_wen[0] === 1'b1) wen_seen++;
    end
    total_cnt++;
    if (cyc !== 3 || wen_seen !== 0)
      $display("FAIL rd_timing got=cyc%0d wen%0d exp=cyc3 wen0", cyc, wen_seen);
    else pass_cnt++;
    total_cnt++;
    if (resp_rdata[0] !== 32'h1234_5678 || resp_err[0] !== 1'b0)
      $display("FAIL rd_data got=%h e%b exp=12345678 e0", resp_rdata[0], resp_err[0]);
    else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_stall();
    bit ok;
    int e0;
    e0 = en_cnt[0];
    resp_ready[0] = 1'b0;
    send(0, 1'b1, 18'h00110, 32'h1111_0000, ok);
    req_write[0] = 1'b1;
    req_addr[0]  = 18'h00120;
    req_wdata[0] = 32'h2222_0000;
    req_valid[0] = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (!ok || resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || en_cnt[0] - e0 !== 1)
      $display("FAIL stall got=ok%0d v%b rdy%b en_pulses%0d exp=ok1 v1 rdy0 en_pulses1",
               ok, resp_valid[0], req_ready[0], en_cnt[0] - e0);
    else pass_cnt++;
    total_cnt++;
    if (cbus_addr[0] !== 18'h00110 || cbus_din[0] !== 32'h1111_0000)
      $display("FAIL stall_nolatch got=%h/%h exp=00110/11110000", cbus_addr[0], cbus_din[0]);
    else pass_cnt++;
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic        qw [4];
    logic [17:0] qa [4];
    logic [31:0] exp_d [4];
    logic [31:0] got_d [4];
    int nreq, nrsp, viol, e0;
    bit acc, rsp, prev_en;
    qw = '{1'b1, 1'b0, 1'b1, 1'b0};
    qa = '{18'h00104, 18'h00208, 18'h00210, 18'h00104};
    exp_d = '{32'h0, 32'h1234_5678, 32'h0, 32'hC000_0104};
    got_d = '{default: 32'h0};
    nreq = 0; nrsp = 0; viol = 0; prev_en = 1'b0;
    e0 = en_cnt[0];
    req_write[0] = qw[0]; req_addr[0] = qa[0]; req_wdata[0] = 32'hA5A5_0002;
    req_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && nrsp < 4; cyc++) begin
      resp_ready[0] = (cyc % 2 == 0);
      acc = req_valid[0] && req_ready[0];
      rsp = resp_valid[0] && resp_ready[0];
      if (resp_valid[0] && req_ready[0]) viol++;
      if (cbus_en[0] && prev_en) viol++;
      prev_en = cbus_en[0];
      if (rsp) begin
        got_d[nrsp] = resp_rdata[0];
        nrsp++;
      end
      tick();
      if (acc) begin
        nreq++;
        if (nreq < 4) begin
          req_write[0] = qw[nreq];
          req_addr[0]  = qa[nreq];
          req_wdata[0] = 32'hA5A5_0002 + 32'(nreq);
        end else req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    total_cnt++;
    if (nrsp !== 4 || viol !== 0 || en_cnt[0] - e0 !== 4)
      $display("FAIL b2b_flow got=rsp%0d viol%0d en_pulses%0d exp=rsp4 viol0 en_pulses4",
               nrsp, viol, en_cnt[0] - e0);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (got_d[k] !== exp_d[k]) $display("FAIL b2b_data%0d got=%h exp=%h", k, got_d[k], exp_d[k]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int cyc;
    int stale;
    send(0, 1'b0, 18'h00208, 32'h0, ok);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (!ok || cbus_en[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || cbus_addr[0] !== 18'h0)
      $display("FAIL rst_async got=ok%0d en%b v%b rdy%b a%h exp=ok1 en0 v0 rdy0 a0",
               ok, cbus_en[0], resp_valid[0], req_ready[0], cbus_addr[0]);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      tick();
      if (resp_valid[0] !== 1'b0) stale++;
    end
    total_cnt++;
    if (stale !== 0) $display("FAIL rst_stale got=%0d exp=0", stale);
    else pass_cnt++;
    send(0, 1'b0, 18'h00208, 32'h0, ok);
    wait_resp(0, cyc);
    total_cnt++;
    if (!ok || cyc !== 3 || resp_rdata[0] !== 32'h1234_5678)
      $display("FAIL rst_next_rd got=ok%0d cyc%0d d%h exp=ok1 cyc3 d12345678", ok, cyc, resp_rdata[0]);
    else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_latency(input int i);
    bit ok;
    int cyc;
    send(i, 1'b0, 18'h00104, 32'h0, ok);
    wait_resp(i, cyc);
    total_cnt++;
    if (!ok || cyc !== 1 + lat_of(i))
      $display("FAIL lat%0d_timing got=ok%0d cyc%0d exp=ok1 cyc%0d", lat_of(i), ok, cyc, 1 + lat_of(i));
    else pass_cnt++;
    total_cnt++;
    if (resp_rdata[i] !== 32'hC000_0104 || resp_err[i] !== 1'b0 || cbus_din[i] !== 32'h0)
      $display("FAIL lat%0d_data got=%h e%b din%h exp=c0000104 e0 din0",
               lat_of(i), resp_rdata[i], resp_err[i], cbus_din[i]);
    else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_unmapped();
    bit ok;
    int cyc;
    int e0;
    e0 = en_cnt[0];
    send(0, 1'b0, 18'h3f000, 32'h0, ok);
`ifdef CBUS_DECERR_EN
    total_cnt++;
    if (!ok || cbus_en[0] !== 1'b0) $display("FAIL decerr_noen got=ok%0d en%b exp=ok1 en0", ok, cbus_en[0]);
    else pass_cnt++;
    wait_resp(0, cyc);
    total_cnt++;
    if (cyc !== 1 || resp_err[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEEF || en_cnt[0] - e0 !== 0)
      $display("FAIL decerr_resp got=cyc%0d e%b d%h en_pulses%0d exp=cyc1 e1 deadbeef en_pulses0",
               cyc, resp_err[0], resp_rdata[0], en_cnt[0] - e0);
    else pass_cnt++;
`else
    total_cnt++;
    if (!ok || cbus_en[0] !== 1'b1) $display("FAIL unmapped_en got=ok%0d en%b exp=ok1 en1", ok, cbus_en[0]);
    else pass_cnt++;
    wait_resp(0, cyc);
    total_cnt++;
    if (cyc !== 3 || resp_err[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || en_cnt[0] - e0 !== 1)
      $display("FAIL unmapped_resp got=cyc%0d e%b d%h en_pulses%0d exp=cyc3 e0 0 en_pulses1",
               cyc, resp_err[0], resp_rdata[0], en_cnt[0] - e0);
    else pass_cnt++;
`endif
    tick();
    tick();
    send(0, 1'b0, 18'h00208, 32'h0, ok);
    wait_resp(0, cyc);
    total_cnt++;
    if (!ok || cyc !== 3 || resp_err[0] !== 1'b0 || resp_rdata[0] !== 32'h1234_5678)
      $display("FAIL mapped_after got=ok%0d cyc%0d e%b d%h exp=ok1 cyc3 e0 12345678",
               ok, cyc, resp_err[0], resp_rdata[0]);
    else pass_cnt++;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 18'h0;
      req_wdata[i] = 32'h0;
      resp_ready[i] = 1'b1;
      pv[i] = 8'h0;
      en_cnt[i] = 0;
      for (int k = 0; k < 8; k++) pa[i][k] = 18'h0;
    end
    repeat (3) tick();
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_reset_mid_read();
    test_latency(1);
    test_latency(2);
    test_unmapped();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
